// File: rtl/dbg_halt_ctrl_pkg.sv
// Shared types and default constants for the multi-hart debug halt/resume controller.
package dbg_halt_ctrl_pkg;

    typedef enum logic [1:0] {
        RUNNING     = 2'd0,
        HALT_PEND   = 2'd1,
        HALTED      = 2'd2,
        RESUME_PEND = 2'd3
    } dbg_hart_state_e;

    localparam logic [31:0] DEF_HALT_ADDR      = 32'h1A11_0800;
    localparam logic [31:0] DEF_EXC_ADDR       = 32'h1A11_0808;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dbg_hart_fsm.sv
// One hart's halt/resume handshake FSM with request timeout and sticky status flags.
module dbg_hart_fsm
    import dbg_halt_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic ackhavereset_i,
    input  logic debug_havereset_i,
    input  logic debug_running_i,
    input  logic debug_halted_i,
    output logic debug_req_o,
    output logic resume_req_o,
    output logic halted_o,
    output logic running_o,
    output logic havereset_o,
    output logic timeout_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dbg_hart_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             havereset_q, havereset_d;
    logic             expired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUNNING;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            havereset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            havereset_q <= havereset_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        expired   = (cnt_q == CNT_LAST);
        // A core reset overrides any handshake in flight; the timeout flag is left alone.
        if (debug_havereset_i) begin
            state_d = RUNNING;
        end else begin
            case (state_q)
                RUNNING: begin
                    if (debug_halted_i) begin
                        state_d = HALTED;
                    end else if (haltreq_i) begin
                        state_d   = HALT_PEND;
                        timeout_d = 1'b0;
                    end
                end
                HALT_PEND: begin
                    if (debug_halted_i) begin
                        state_d = HALTED;
                    end else if (expired) begin
                        state_d   = RUNNING;
                        timeout_d = 1'b1;
                    end
                end
                HALTED: begin
                    if (resumereq_i) begin
                        state_d   = RESUME_PEND;
                        timeout_d = 1'b0;
                    end
                end
                RESUME_PEND: begin
                    if (debug_running_i && !debug_halted_i) begin
                        state_d = RUNNING;
                    end else if (expired) begin
                        state_d   = HALTED;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = RUNNING;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == HALT_PEND || state_q == RESUME_PEND) && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Set wins over a simultaneous acknowledge.
        havereset_d = debug_havereset_i | (havereset_q & ~ackhavereset_i);
    end

    always_comb begin
        debug_req_o  = (state_q == HALT_PEND);
        resume_req_o = (state_q == RESUME_PEND);
        halted_o     = (state_q == HALTED);
        running_o    = (state_q == RUNNING);
        timeout_o    = timeout_q;
        havereset_o  = havereset_q;
    end

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug halt/resume controller: one FSM per hart plus shared entry addresses and summary flags.
module dbg_halt_ctrl
    import dbg_halt_ctrl_pkg::*;
#(
    parameter int unsigned        NUM_HARTS      = 4,
    parameter int unsigned        ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]  HALT_ADDR      = ADDR_W'(DEF_HALT_ADDR),
    parameter logic [ADDR_W-1:0]  EXC_ADDR       = ADDR_W'(DEF_EXC_ADDR),
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_HARTS-1:0] haltreq_i,
    input  logic [NUM_HARTS-1:0] resumereq_i,
    input  logic [NUM_HARTS-1:0] ackhavereset_i,
    input  logic [NUM_HARTS-1:0] debug_havereset_i,
    input  logic [NUM_HARTS-1:0] debug_running_i,
    input  logic [NUM_HARTS-1:0] debug_halted_i,
    output logic [NUM_HARTS-1:0] debug_req_o,
    output logic [NUM_HARTS-1:0] resume_req_o,
    output logic [ADDR_W-1:0]    dm_halt_addr_o,
    output logic [ADDR_W-1:0]    dm_exception_addr_o,
    output logic [NUM_HARTS-1:0] halted_o,
    output logic [NUM_HARTS-1:0] running_o,
    output logic [NUM_HARTS-1:0] havereset_o,
    output logic [NUM_HARTS-1:0] timeout_o,
    output logic                 anyhalted_o,
    output logic                 allhalted_o,
    output logic                 anyrunning_o,
    output logic                 allrunning_o
);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        dbg_hart_fsm #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_fsm (
            .clk_i            (clk_i),
            .rst_ni           (rst_ni),
            .haltreq_i        (haltreq_i[h]),
            .resumereq_i      (resumereq_i[h]),
            .ackhavereset_i   (ackhavereset_i[h]),
            .debug_havereset_i(debug_havereset_i[h]),
            .debug_running_i  (debug_running_i[h]),
            .debug_halted_i   (debug_halted_i[h]),
            .debug_req_o      (debug_req_o[h]),
            .resume_req_o     (resume_req_o[h]),
            .halted_o         (halted_o[h]),
            .running_o        (running_o[h]),
            .havereset_o      (havereset_o[h]),
            .timeout_o        (timeout_o[h])
        );
    end

    assign dm_halt_addr_o      = HALT_ADDR;
    assign dm_exception_addr_o = EXC_ADDR;

    // Summaries come straight off the registered per-hart status, no added latency.
    assign anyhalted_o  = |halted_o;
    assign allhalted_o  = &halted_o;
    assign anyrunning_o = |running_o;
    assign allrunning_o = &running_o;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Randomized and directed bench for dbg_halt_ctrl against a request-tracking reference model.
module tb_dbg_halt_ctrl;

    localparam int NH = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NH-1:0] haltreq, resumereq, ack, hr_i, run_i, halt_i;
    logic [NH-1:0] debug_req, resume_req, halted, running, havereset, timeout;
    logic [31:0]   halt_addr, exc_addr;
    logic          anyhalted, allhalted, anyrunning, allrunning;

    dbg_halt_ctrl #(
        .NUM_HARTS(NH), .ADDR_W(32), .HALT_ADDR(32'h1A11_0800),
        .EXC_ADDR(32'h1A11_0808), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .haltreq_i(haltreq), .resumereq_i(resumereq), .ackhavereset_i(ack),
        .debug_havereset_i(hr_i), .debug_running_i(run_i), .debug_halted_i(halt_i),
        .debug_req_o(debug_req), .resume_req_o(resume_req),
        .dm_halt_addr_o(halt_addr), .dm_exception_addr_o(exc_addr),
        .halted_o(halted), .running_o(running), .havereset_o(havereset), .timeout_o(timeout),
        .anyhalted_o(anyhalted), .allhalted_o(allhalted),
        .anyrunning_o(anyrunning), .allrunning_o(allrunning)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: which side the core is on (halted or not), whether a request is in flight, and its age.
    bit m_side_halted[NH];
    bit m_inflight[NH];
    int m_age[NH];
    bit m_to[NH];
    bit m_hr[NH];

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_side_halted[h] = 0; m_inflight[h] = 0; m_age[h] = 0; m_to[h] = 0; m_hr[h] = 0;
        end
    endtask

    task automatic model_step();
        for (int h = 0; h < NH; h++) begin
            bit done;
            if (hr_i[h]) begin
                m_side_halted[h] = 0; m_inflight[h] = 0; m_age[h] = 0;
            end else if (!m_inflight[h]) begin
                if (!m_side_halted[h]) begin
                    if (halt_i[h]) m_side_halted[h] = 1;
                    else if (haltreq[h]) begin m_inflight[h] = 1; m_age[h] = 0; m_to[h] = 0; end
                end else if (resumereq[h]) begin
                    m_inflight[h] = 1; m_age[h] = 0; m_to[h] = 0;
                end
            end else begin
                // Halt completes on halted; resume completes on running and not halted.
                done = m_side_halted[h] ? (run_i[h] && !halt_i[h]) : halt_i[h];
                if (done) begin
                    m_inflight[h] = 0; m_side_halted[h] = !m_side_halted[h];
                end else if (m_age[h] + 1 >= TO) begin
                    m_inflight[h] = 0; m_to[h] = 1;
                end else begin
                    m_age[h] = m_age[h] + 1;
                end
            end
            m_hr[h] = hr_i[h] || (m_hr[h] && !ack[h]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            logic [NH-1:0] e_dreq, e_rreq, e_halt, e_run, e_to, e_hr;
            for (int h = 0; h < NH; h++) begin
                e_dreq[h] = m_inflight[h] && !m_side_halted[h];
                e_rreq[h] = m_inflight[h] && m_side_halted[h];
                e_halt[h] = !m_inflight[h] && m_side_halted[h];
                e_run[h]  = !m_inflight[h] && !m_side_halted[h];
                e_to[h]   = m_to[h];
                e_hr[h]   = m_hr[h];
            end
            chk("model debug_req_o", 32'(debug_req), 32'(e_dreq));
            chk("model resume_req_o", 32'(resume_req), 32'(e_rreq));
            chk("model halted_o", 32'(halted), 32'(e_halt));
            chk("model running_o", 32'(running), 32'(e_run));
            chk("model timeout_o", 32'(timeout), 32'(e_to));
            chk("model havereset_o", 32'(havereset), 32'(e_hr));
            chk("model anyhalted_o", 32'(anyhalted), 32'(e_halt != '0));
            chk("model allhalted_o", 32'(allhalted), 32'(e_halt == '1));
            chk("model anyrunning_o", 32'(anyrunning), 32'(e_run != '0));
            chk("model allrunning_o", 32'(allrunning), 32'(e_run == '1));
        end
    end

    initial begin
        int n;
        haltreq = '0; resumereq = '0; ack = '0; hr_i = '0; run_i = '0; halt_i = '0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset running_o", 32'(running), 32'hF);
        chk("reset allrunning_o", 32'(allrunning), 32'h1);
        rst_n = 1'b1;

        // Halt hart 2, core reports halted in cycle 3.
        haltreq = 4'b0100;
        step(); chk("h2 debug_req c1", 32'(debug_req), 32'h4);
        step(); chk("h2 debug_req c2", 32'(debug_req), 32'h4);
        step(); chk("h2 debug_req c3", 32'(debug_req), 32'h4);
        halt_i[2] = 1'b1;
        step();
        chk("h2 debug_req c4", 32'(debug_req), 32'h0);
        chk("h2 halted_o c4", 32'(halted), 32'h4);
        chk("h2 anyhalted c4", 32'(anyhalted), 32'h1);
        chk("h2 allhalted c4", 32'(allhalted), 32'h0);
        haltreq = '0;

        // Hart 0 halt timeout.
        haltreq[0] = 1'b1;
        step();
        haltreq[0] = 1'b0;
        n = 0;
        while (debug_req[0] && n < 20) begin n++; step(); end
        chk("h0 debug_req high cycles", 32'(n), 32'd8);
        chk("h0 running after timeout", 32'(running[0]), 32'h1);
        chk("h0 timeout_o set", 32'(timeout[0]), 32'h1);
        haltreq[0] = 1'b1;
        step();
        haltreq[0] = 1'b0;
        chk("h0 timeout_o cleared", 32'(timeout[0]), 32'h0);
        chk("h0 debug_req re-armed", 32'(debug_req[0]), 32'h1);
        halt_i[0] = 1'b1;
        step();
        halt_i[0] = 1'b0;
        chk("h0 halted", 32'(halted[0]), 32'h1);

        // Resume hart 0, core reports running after two cycles.
        resumereq[0] = 1'b1;
        step();
        resumereq[0] = 1'b0;
        chk("h0 resume_req r1", 32'(resume_req[0]), 32'h1);
        step(); chk("h0 resume_req r2", 32'(resume_req[0]), 32'h1);
        run_i[0] = 1'b1;
        step();
        run_i[0] = 1'b0;
        chk("h0 resume_req dropped", 32'(resume_req[0]), 32'h0);
        chk("h0 running after resume", 32'(running[0]), 32'h1);
        chk("h0 halted after resume", 32'(halted[0]), 32'h0);

        // Hart 3 core reset during a pending halt.
        haltreq[3] = 1'b1;
        step();
        haltreq[3] = 1'b0;
        chk("h3 debug_req pend", 32'(debug_req[3]), 32'h1);
        hr_i[3] = 1'b1;
        step();
        chk("h3 debug_req dropped", 32'(debug_req[3]), 32'h0);
        chk("h3 running forced", 32'(running[3]), 32'h1);
        chk("h3 havereset set", 32'(havereset[3]), 32'h1);
        ack[3] = 1'b1;
        step();
        ack[3] = 1'b0;
        chk("h3 havereset set+ack", 32'(havereset[3]), 32'h1);
        hr_i[3] = 1'b0;
        step();
        chk("h3 havereset held", 32'(havereset[3]), 32'h1);
        ack[3] = 1'b1;
        step();
        ack[3] = 1'b0;
        chk("h3 havereset acked", 32'(havereset[3]), 32'h0);

        // Asynchronous reset mid-cycle with hart 2 halted and hart 1 havereset pending.
        hr_i[1] = 1'b1;
        step();
        hr_i[1] = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("areset halted_o", 32'(halted), 32'h0);
        chk("areset running_o", 32'(running), 32'hF);
        chk("areset havereset_o", 32'(havereset), 32'h0);
        chk("areset debug_req_o", 32'(debug_req | resume_req | timeout), 32'h0);
        chk("areset allrunning_o", 32'(allrunning), 32'h1);
        chk("areset anyhalted_o", 32'(anyhalted), 32'h0);
        chk("dm_halt_addr_o", halt_addr, 32'h1A11_0800);
        chk("dm_exception_addr_o", exc_addr, 32'h1A11_0808);
        halt_i = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // All harts halting, cores halt in cycles 2..5.
        haltreq = 4'hF;
        step(); step();
        halt_i[0] = 1'b1; step();
        halt_i[1] = 1'b1; step();
        halt_i[2] = 1'b1; step();
        halt_i[3] = 1'b1;
        chk("all allhalted before", 32'(allhalted), 32'h0);
        step();
        chk("all allhalted after", 32'(allhalted), 32'h1);
        haltreq = '0; halt_i = '0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            for (int h = 0; h < NH; h++) begin
                haltreq[h]   = ($urandom_range(0, 3) == 0);
                resumereq[h] = ($urandom_range(0, 3) == 0);
                halt_i[h]    = ($urandom_range(0, 4) == 0);
                run_i[h]     = ($urandom_range(0, 2) == 0);
                hr_i[h]      = ($urandom_range(0, 31) == 0);
                ack[h]       = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        haltreq = '0; resumereq = '0; ack = '0; hr_i = '0; run_i = '0; halt_i = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
